// File: rtl/mult_block_host.sv
// Block initiator for the multiplier: issues DEPTH operand pairs, requests read-back,
// collects and re-emits the results with a running sum and a completion pulse.
module mult_block_host #(
  parameter int unsigned N       = 32,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic         IN_valid,
  output logic         IN_ready,
  input  logic [15:0]  IN_op0,
  input  logic [15:0]  IN_op1,
  input  logic         RDY_mult,
  output logic         EN_mult,
  output logic [15:0]  mult_input0,
  output logic [15:0]  mult_input1,
  output logic         EN_blockRead,
  input  logic         VALID_memVal,
  input  logic [N-1:0] memVal_data,
  output logic         OUT_valid,
  output logic [N-1:0] OUT_data,
  output logic [5:0]   OUT_index,
  output logic [N+5:0] SUM,
  output logic         DONE,
  output logic         BUSY,
  output logic         ERR
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StDrain,
    StReq,
    StCollect,
    StDone
  } state_e;

  state_e        state;
  logic [CW-1:0] issue_cnt;
  logic [CW-1:0] rx_cnt;
  logic [TW-1:0] timer;
  logic          take_word;
  logic          spurious;
  logic          last_word;
  logic          timed_out;

  assign BUSY         = (state != StIdle);
  assign IN_ready     = (state == StIssue) && RDY_mult && (issue_cnt < CW'(DEPTH));
  assign EN_mult      = IN_valid && IN_ready;
  assign mult_input0  = IN_op0;
  assign mult_input1  = IN_op1;
  assign EN_blockRead = (state == StReq);
  assign DONE         = (state == StDone);

  assign take_word = VALID_memVal && ((state == StReq) || (state == StCollect));
  assign spurious  = VALID_memVal &&
                     ((state == StIdle) || (state == StIssue) || (state == StDrain));
  assign last_word = (rx_cnt == CW'(DEPTH - 1));
  assign timed_out = (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= StIdle;
      issue_cnt <= '0;
      rx_cnt    <= '0;
      timer     <= '0;
      OUT_valid <= 1'b0;
      OUT_data  <= '0;
      OUT_index <= '0;
      SUM       <= '0;
      ERR       <= 1'b0;
    end else begin
      OUT_valid <= 1'b0;
      // Stray read-back data is flagged but never alters the flow.
      if (spurious) ERR <= 1'b1;

      if (take_word) begin
        OUT_valid <= 1'b1;
        OUT_data  <= memVal_data;
        OUT_index <= rx_cnt[5:0];
        SUM       <= SUM + {6'd0, memVal_data};
        rx_cnt    <= rx_cnt + 1'b1;
      end

      unique case (state)
        StIdle: begin
          if (START) begin
            state     <= StIssue;
            SUM       <= '0;
            issue_cnt <= '0;
            rx_cnt    <= '0;
          end
        end
        StIssue: begin
          if (EN_mult) begin
            issue_cnt <= issue_cnt + 1'b1;
            if (issue_cnt == CW'(DEPTH - 1)) begin
              state <= StDrain;
              timer <= '0;
            end
          end
        end
        StDrain: begin
          // RDY_mult low means every entry has been written and the block is full.
          if (!RDY_mult) begin
            state <= StReq;
            timer <= '0;
          end else if (timed_out) begin
            ERR   <= 1'b1;
            state <= StIdle;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        StReq: begin
          if (VALID_memVal) begin
            state <= last_word ? StDone : StCollect;
          end else if (timed_out) begin
            ERR   <= 1'b1;
            state <= StIdle;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        StCollect: begin
          if (VALID_memVal && last_word) state <= StDone;
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule
